// File: rtl/ifc_pkg.sv
// Shared types and constants for the IFC receive word packer.
package ifc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVEN   = 2'd1,
    ODD    = 2'd2,
    CRC_WR = 2'd3
  } ifc_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [7:0]  PAD_BYTE = 8'h00;

  // CRC-16/CCITT-FALSE, one byte, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/ifc_crc16.sv
// Registered byte-wise CRC-16 accumulator with clear/enable.
module ifc_crc16
  import ifc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // clr together with en restarts the CRC from the seed and folds in this byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_byte(clr ? CRC_INIT : crc, data);
    end else if (clr) begin
      crc <= CRC_INIT;
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/ifc_word_packer.sv
// Packs framed IFC bytes into 16-bit buffer words and tracks buffer occupancy.
// Optional trailing CRC word is enabled with the IFC_PACKER_CRC_EN macro.
module ifc_word_packer
  import ifc_pkg::*;
#(
  parameter int BUFFER_SIZE    = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LEVEL_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   frame_start,
  input  logic                   frame_end,
  output logic                   byte_ready,
  input  logic                   buf_read,
  output logic                   write_enable,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   overflow,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_FULL = LEVEL_WIDTH'(BUFFER_SIZE);
`ifdef IFC_PACKER_CRC_EN
  localparam ifc_state_e END_STATE = CRC_WR;
`else
  localparam ifc_state_e END_STATE = IDLE;
`endif

  ifc_state_e            state_r;
  ifc_state_e            next_state_s;
  logic [7:0]            hold_r;
  logic [TW-1:0]         tmo_cnt_r;
  logic                  accept_s;
  logic                  in_frame_s;
  logic                  load_hold_s;
  logic                  word_due_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  err_s;
  logic                  tmo_fire_s;
  logic                  read_eff_s;
  logic [LEVEL_WIDTH-1:0] level_next_s;
  logic                  full_s;

  assign accept_s   = byte_valid & byte_ready;
  assign in_frame_s = (state_r == EVEN) || (state_r == ODD);
  assign read_eff_s = buf_read && (level != '0);

`ifdef IFC_PACKER_CRC_EN
  logic [15:0] crc_s;
  logic        crc_clr_s;
  logic        crc_en_s;

  assign crc_clr_s = accept_s && frame_start;
  assign crc_en_s  = accept_s && (frame_start || in_frame_s);

  ifc_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr_s),
    .en    (crc_en_s),
    .data  (byte_data),
    .crc   (crc_s)
  );
`endif

  // Occupancy as it will be after this cycle's registered write and read.
  always_comb begin
    level_next_s = level;
    case ({write_enable, read_eff_s})
      2'b10:   level_next_s = level + LEVEL_WIDTH'(1);
      2'b01:   level_next_s = level - LEVEL_WIDTH'(1);
      default: level_next_s = level;
    endcase
  end

  assign full_s = (level_next_s >= LVL_FULL);

  // Next-state, word assembly and error detection.
  always_comb begin
    next_state_s = state_r;
    load_hold_s  = 1'b0;
    word_due_s   = 1'b0;
    word_s       = '0;
    err_s        = 1'b0;
    tmo_fire_s   = 1'b0;
    if (accept_s) begin
      if (frame_start) begin
        // A start inside a frame abandons the old frame and restarts here.
        err_s = (state_r != IDLE);
        if (frame_end) begin
          word_due_s   = 1'b1;
          word_s       = {byte_data, PAD_BYTE};
          next_state_s = END_STATE;
        end else begin
          load_hold_s  = 1'b1;
          next_state_s = ODD;
        end
      end else begin
        case (state_r)
          EVEN: begin
            if (frame_end) begin
              word_due_s   = 1'b1;
              word_s       = {byte_data, PAD_BYTE};
              next_state_s = END_STATE;
            end else begin
              load_hold_s  = 1'b1;
              next_state_s = ODD;
            end
          end
          ODD: begin
            word_due_s   = 1'b1;
            word_s       = {hold_r, byte_data};
            next_state_s = frame_end ? END_STATE : EVEN;
          end
          default: err_s = 1'b1;
        endcase
      end
    end else if (in_frame_s && (tmo_cnt_r == TMO_LAST)) begin
      tmo_fire_s   = 1'b1;
      err_s        = 1'b1;
      next_state_s = IDLE;
      if (state_r == ODD) begin
        word_due_s = 1'b1;
        word_s     = {hold_r, PAD_BYTE};
      end else begin
        word_due_s = 1'b0;
      end
`ifdef IFC_PACKER_CRC_EN
    end else if (state_r == CRC_WR) begin
      word_due_s   = 1'b1;
      word_s       = {crc_s[15:8], crc_s[7:0]};
      next_state_s = IDLE;
`endif
    end else begin
      next_state_s = state_r;
    end
  end

  // State, timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hold_r       <= 8'h00;
      tmo_cnt_r    <= '0;
      write_enable <= 1'b0;
      wr_data      <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      busy      <= (next_state_s != IDLE);
      frame_err <= err_s;
      level     <= level_next_s;
      if (load_hold_s) begin
        hold_r <= byte_data;
      end
      if (accept_s || tmo_fire_s || !in_frame_s) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
      write_enable <= word_due_s && !full_s;
      if (word_due_s && !full_s) begin
        wr_data <= word_s;
      end
      if (word_due_s && full_s) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef IFC_PACKER_CRC_EN
  // Input is stalled for the single cycle spent emitting the CRC word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_ready <= 1'b1;
    end else begin
      byte_ready <= (next_state_s != CRC_WR);
    end
  end
`else
  assign byte_ready = 1'b1;
`endif

endmodule

// File: tb/tb_ifc_word_packer.sv
// Directed self-checking bench for ifc_word_packer.
module tb_ifc_word_packer;

  localparam int BUFFER_SIZE    = 10;
  localparam int TIMEOUT_CYCLES = 255;
`ifdef IFC_PACKER_CRC_EN
  localparam int CRCW = 1;
`else
  localparam int CRCW = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_start;
  logic        frame_end;
  logic        byte_ready;
  logic        buf_read;
  logic        write_enable;
  logic [15:0] wr_data;
  logic [7:0]  level;
  logic        overflow;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  logic [15:0] wq[$];

  ifc_word_packer #(
    .BUFFER_SIZE(BUFFER_SIZE), .DATA_WIDTH(16),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LEVEL_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_start(frame_start), .frame_end(frame_end), .byte_ready(byte_ready),
    .buf_read(buf_read), .write_enable(write_enable), .wr_data(wr_data),
    .level(level), .overflow(overflow), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record buffer writes and error pulses away from the active edge.
  always @(negedge clk) begin
    if (write_enable) wq.push_back(wr_data);
    if (frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wget(input int i);
    return (i < wq.size()) ? wq[i] : 16'hDEAD;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic e);
    int guard = 0;
    byte_valid = 1'b1; byte_data = d; frame_start = s; frame_end = e;
    while (!byte_ready && guard < 8) begin
      wait_cycles(1);
      guard++;
    end
    if (guard == 8) check("ready_wait", 32'(byte_ready), 32'd1);
    wait_cycles(1);
    byte_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
  endtask

  task automatic drain(input int n);
    buf_read = 1'b1;
    wait_cycles(n);
    buf_read = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    frame_start = 1'b0; frame_end = 1'b0; buf_read = 1'b0;
    wait_cycles(3);
    check("rst_we",    32'(write_enable), 32'd0);
    check("rst_wdata", 32'(wr_data),      32'd0);
    check("rst_level", 32'(level),        32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
    check("rst_ferr",  32'(frame_err),    32'd0);
    check("rst_ready", 32'(byte_ready),   32'd1);
    check("rst_busy",  32'(busy),         32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Even frame
    wq.delete(); ferr_cnt = 0;
    drive(8'hA1, 1'b1, 1'b0);
    check("even_busy_mid", 32'(busy), 32'd1);
    drive(8'hB2, 1'b0, 1'b0);
    drive(8'hC3, 1'b0, 1'b0);
    drive(8'hD4, 1'b0, 1'b1);
    check("even_busy_end", 32'(busy), 32'(CRCW));
    wait_cycles(3);
    check("even_w0",    32'(wget(0)),    32'h0000A1B2);
    check("even_w1",    32'(wget(1)),    32'h0000C3D4);
    check("even_nw",    32'(wq.size()),  32'(2 + CRCW));
    check("even_level", 32'(level),      32'(2 + CRCW));
    check("even_busy",  32'(busy),       32'd0);

    // Odd frame, pad byte appended
    wq.delete(); ferr_cnt = 0;
    drive(8'h11, 1'b1, 1'b0);
    drive(8'h22, 1'b0, 1'b0);
    drive(8'h33, 1'b0, 1'b1);
    wait_cycles(3);
    check("odd_w0",    32'(wget(0)),   32'h00001122);
    check("odd_w1",    32'(wget(1)),   32'h00003300);
    check("odd_ferr",  32'(ferr_cnt),  32'd0);
    check("odd_level", 32'(level),     32'(4 + 2 * CRCW));
    drain(12);
    check("drain_level0", 32'(level), 32'd0);

    // Fill past capacity
    wq.delete();
    for (int i = 0; i < 22; i++) begin
      drive(8'(i + 1), (i == 0), (i == 21));
      if (i == 19) check("ovf_before", 32'(overflow), 32'd0);
    end
    wait_cycles(3);
    check("full_nw",    32'(wq.size()), 32'd10);
    check("full_w0",    32'(wget(0)),   32'h00000102);
    check("full_w9",    32'(wget(9)),   32'h00001314);
    check("full_ovf",   32'(overflow),  32'd1);
    check("full_level", 32'(level),     32'd10);
    wq.delete();
    drive(8'hE1, 1'b1, 1'b0);
    buf_read = 1'b1;
    drive(8'hE2, 1'b0, 1'b1);
    buf_read = 1'b0;
    wait_cycles(3);
    check("full_rw_w",     32'(wget(0)), 32'h0000E1E2);
    check("full_rw_level", 32'(level),   32'd10);
    drain(12);
    check("drain2_level0", 32'(level), 32'd0);

    // Timeout with a held byte
    wq.delete(); ferr_cnt = 0;
    drive(8'h5A, 1'b1, 1'b0);
    wait_cycles(TIMEOUT_CYCLES - 1);
    check("tmo_ferr_early", 32'(frame_err), 32'd0);
    check("tmo_busy_early", 32'(busy),      32'd1);
    wait_cycles(1);
    check("tmo_ferr", 32'(frame_err),    32'd1);
    check("tmo_we",   32'(write_enable), 32'd1);
    check("tmo_data", 32'(wr_data),      32'h00005A00);
    check("tmo_busy", 32'(busy),         32'd0);
    wait_cycles(3);
    check("tmo_ferr_cnt", 32'(ferr_cnt),  32'd1);
    check("tmo_nw",       32'(wq.size()), 32'd1);
    check("tmo_level",    32'(level),     32'd1);

    // Stray byte in IDLE
    wq.delete(); ferr_cnt = 0;
    drive(8'h77, 1'b0, 1'b0);
    check("stray_ferr", 32'(frame_err), 32'd1);
    wait_cycles(3);
    check("stray_ferr_cnt", 32'(ferr_cnt),  32'd1);
    check("stray_nw",       32'(wq.size()), 32'd0);
    check("stray_busy",     32'(busy),      32'd0);

    // frame_start inside a frame restarts it
    wq.delete(); ferr_cnt = 0;
    drive(8'h10, 1'b1, 1'b0);
    drive(8'h20, 1'b1, 1'b0);
    drive(8'h30, 1'b0, 1'b1);
    wait_cycles(3);
    check("restart_ferr", 32'(ferr_cnt),  32'd1);
    check("restart_w0",   32'(wget(0)),   32'h00002030);
    check("restart_nw",   32'(wq.size()), 32'(1 + CRCW));

`ifdef IFC_PACKER_CRC_EN
    // Check string "123456789"
    wq.delete();
    for (int i = 0; i < 9; i++) begin
      drive(8'h31 + 8'(i), (i == 0), (i == 8));
    end
    check("crc_ready_low", 32'(byte_ready), 32'd0);
    wait_cycles(1);
    check("crc_ready_high", 32'(byte_ready), 32'd1);
    wait_cycles(3);
    check("crc_w0", 32'(wget(0)), 32'h00003132);
    check("crc_w1", 32'(wget(1)), 32'h00003334);
    check("crc_w2", 32'(wget(2)), 32'h00003536);
    check("crc_w3", 32'(wget(3)), 32'h00003738);
    check("crc_w4", 32'(wget(4)), 32'h00003900);
    check("crc_w5", 32'(wget(5)), 32'h000029B1);
    check("crc_nw", 32'(wq.size()), 32'd6);
`endif

    // Reset while a byte is held
    check("ovf_sticky", 32'(overflow), 32'd1);
    wq.delete();
    drive(8'h7E, 1'b1, 1'b0);
    rst_n = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    check("mrst_we",    32'(write_enable), 32'd0);
    check("mrst_level", 32'(level),        32'd0);
    check("mrst_ovf",   32'(overflow),     32'd0);
    check("mrst_busy",  32'(busy),         32'd0);
    wait_cycles(3);
    check("mrst_nw",    32'(wq.size()),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
